// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default frame geometry
// used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum bit [1:0] {IDLE, START, DATA, STOP} uart_state_e;

    localparam int UART_CLKS_PER_BIT = 4;
    localparam int UART_DATA_BITS    = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// N-stage single-bit synchronizer for the asynchronous serial line.
// Resets to 1 so an idle-high line never looks like a start bit.
module uart_rx_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], d};
        end
    end

    assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling FSM feeding a valid/ready holding
// register with framing-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int HALF  = CLKS_PER_BIT / 2;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic rs;

    uart_state_e          state_reg, state_next;
    logic [CNT_W-1:0]     clk_cnt_reg, clk_cnt_next;
    logic [IDX_W-1:0]     bit_idx_reg, bit_idx_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 good_frame, bad_frame;

    logic [DATA_BITS-1:0] rx_data_reg;
    logic                 rx_valid_reg, frame_err_reg, overrun_reg;

    uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rs)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            clk_cnt_reg <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            clk_cnt_reg <= clk_cnt_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clk_cnt_next = clk_cnt_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        good_frame   = 1'b0;
        bad_frame    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!rs) begin
                    state_next   = START;
                    clk_cnt_next = '0;
                end
            end
            START: begin
                if (clk_cnt_reg == CNT_HALF) begin
                    clk_cnt_next = '0;
                    bit_idx_next = '0;
                    // A start bit that has gone high by mid-bit was a glitch.
                    state_next   = rs ? IDLE : DATA;
                end else begin
                    clk_cnt_next = clk_cnt_reg + 1'b1;
                end
            end
            DATA: begin
                if (clk_cnt_reg == CNT_LAST) begin
                    clk_cnt_next            = '0;
                    shift_next[bit_idx_reg] = rs;
                    if (bit_idx_reg == IDX_LAST) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                    end
                end else begin
                    clk_cnt_next = clk_cnt_reg + 1'b1;
                end
            end
            STOP: begin
                // Leave at mid stop bit so a following start edge is caught.
                if (clk_cnt_reg == CNT_LAST) begin
                    clk_cnt_next = '0;
                    state_next   = IDLE;
                    good_frame   = rs;
                    bad_frame    = !rs;
                end else begin
                    clk_cnt_next = clk_cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data_reg   <= '0;
            rx_valid_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            frame_err_reg <= bad_frame;
            overrun_reg   <= 1'b0;
            if (good_frame && (!rx_valid_reg || rx_ready)) begin
                rx_data_reg  <= shift_reg;
                rx_valid_reg <= 1'b1;
            end else if (good_frame) begin
                overrun_reg <= 1'b1;
            end else if (rx_valid_reg && rx_ready) begin
                rx_valid_reg <= 1'b0;
            end
        end
    end

    assign rx_data   = rx_data_reg;
    assign rx_valid  = rx_valid_reg;
    assign frame_err = frame_err_reg;
    assign overrun   = overrun_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a bench-side 8N1 serializer drives rx and a
// negedge monitor records handshakes and error pulses for later checks.
module tb_uart_rx;

    localparam int CPB  = 4;
    localparam int DB   = 8;
    localparam int SYNC = 2;
    localparam int HALF = CPB / 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx;
    logic          rx_ready;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          busy;
    logic          frame_err;
    logic          overrun;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] hs_q[$];
    int ferr_cnt    = 0;
    int ovr_cnt     = 0;
    int busy_cycles = 0;
    int valid_cycles = 0;

    always #5 clk = ~clk;

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DB),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    // Inputs change 1 ns after posedge; outputs are observed on negedge.
    always @(negedge clk) begin
        if (rx_valid && rx_ready) hs_q.push_back(rx_data);
        if (frame_err) ferr_cnt++;
        if (overrun) ovr_cnt++;
        if (busy) busy_cycles++;
        if (rx_valid) valid_cycles++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < DB; i++) begin
            rx = d[i];
            tick(CPB);
        end
        rx = stop_bit;
        tick(CPB);
        rx = 1'b1;
    endtask

    task automatic clear_mon();
        hs_q.delete();
        ferr_cnt     = 0;
        ovr_cnt      = 0;
        busy_cycles  = 0;
        valid_cycles = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst      = 1'b1;
        rx       = 1'b1;
        rx_ready = 1'b0;
        tick(3);

        // Reset state
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_data", 32'(rx_data), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        rst = 1'b0;
        tick(4);

        // Single frame 0xA5, consumer always ready
        clear_mon();
        rx_ready = 1'b1;
        send_frame(8'hA5, 1'b1);
        tick(4);
        check("a5_count", 32'(hs_q.size()), 32'd1);
        check("a5_data", 32'(hs_q.size() > 0 ? hs_q[0] : 8'hxx), 32'hA5);
        check("a5_vcycles", 32'(valid_cycles), 32'd1);
        check("a5_ferr", 32'(ferr_cnt), 32'd0);
        check("a5_ovr", 32'(ovr_cnt), 32'd0);
        check("a5_busy_end", 32'(busy), 32'd0);
        $display("txn A5: handshakes=%0d busy_cycles=%0d", hs_q.size(), busy_cycles);

        // Back-to-back 0x00 then 0xFF
        clear_mon();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        tick(4);
        check("b2b_count", 32'(hs_q.size()), 32'd2);
        check("b2b_data0", 32'(hs_q.size() > 0 ? hs_q[0] : 8'hxx), 32'h00);
        check("b2b_data1", 32'(hs_q.size() > 1 ? hs_q[1] : 8'hxx), 32'hFF);
        check("b2b_ferr", 32'(ferr_cnt), 32'd0);
        check("b2b_ovr", 32'(ovr_cnt), 32'd0);
        $display("txn 00/FF: handshakes=%0d", hs_q.size());

        // One-clock glitch on rx: false start
        clear_mon();
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(HALF + SYNC + 4);
        check("glitch_busy_seen", 32'(busy_cycles > 0), 32'd1);
        check("glitch_busy_short", 32'(busy_cycles <= HALF + SYNC + 1), 32'd1);
        check("glitch_busy_end", 32'(busy), 32'd0);
        check("glitch_valid", 32'(valid_cycles), 32'd0);
        check("glitch_ferr", 32'(ferr_cnt), 32'd0);
        $display("txn glitch: busy_cycles=%0d", busy_cycles);

        // Frame 0x5A with a bad stop bit
        clear_mon();
        send_frame(8'h5A, 1'b0);
        tick(4);
        check("ferr_count", 32'(ferr_cnt), 32'd1);
        check("ferr_valid", 32'(valid_cycles), 32'd0);
        check("ferr_data_kept", 32'(rx_data), 32'hFF);
        check("ferr_ovr", 32'(ovr_cnt), 32'd0);
        $display("txn 5A bad stop: frame_err pulses=%0d", ferr_cnt);

        // Overrun: consumer stalled across two frames
        clear_mon();
        rx_ready = 1'b0;
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        tick(4);
        check("ovr_valid", 32'(rx_valid), 32'd1);
        check("ovr_data", 32'(rx_data), 32'h3C);
        check("ovr_count", 32'(ovr_cnt), 32'd1);
        check("ovr_no_hs", 32'(hs_q.size()), 32'd0);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        check("drain_valid", 32'(rx_valid), 32'd0);
        check("drain_data", 32'(rx_data), 32'h3C);
        check("drain_hs", 32'(hs_q.size()), 32'd1);
        $display("txn 3C/C3 stalled: overrun pulses=%0d handshakes=%0d", ovr_cnt, hs_q.size());

        // Reset mid-DATA of 0x96 aborts the frame silently
        clear_mon();
        rx = 1'b0;
        tick(CPB);
        rx = 1'b0;
        tick(CPB);
        rx = 1'b1;
        tick(CPB);
        rx = 1'b1;
        tick(CPB);
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        rx  = 1'b1;
        tick(1);
        check("mrst_valid", 32'(rx_valid), 32'd0);
        check("mrst_data", 32'(rx_data), 32'h00);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_ferr", 32'(frame_err), 32'd0);
        check("mrst_ovr", 32'(overrun), 32'd0);
        rst = 1'b0;
        tick(40);
        check("abort_hs", 32'(hs_q.size()), 32'd0);
        check("abort_ferr", 32'(ferr_cnt), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);

        clear_mon();
        rx_ready = 1'b1;
        send_frame(8'h81, 1'b1);
        tick(4);
        check("post_count", 32'(hs_q.size()), 32'd1);
        check("post_data", 32'(hs_q.size() > 0 ? hs_q[0] : 8'hxx), 32'h81);
        check("post_ferr", 32'(ferr_cnt), 32'd0);
        check("post_ovr", 32'(ovr_cnt), 32'd0);
        $display("txn 81 after reset: handshakes=%0d", hs_q.size());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
